multicycle_cu: RTL and testbench
================================

# multicycle_cu

Multi-cycle control unit for the 16-bit CPU: a Moore FSM that sequences each instruction through fetch, decode, execute, memory and write-back. It replaces the single-cycle combinational decoder with per-state control strobes and memory wait-state handshakes. It adds a retired-instruction counter and illegal-opcode handling. It sits between the instruction register and the datapath: the PC, register file, ALU control and data memory.

## Interface
- OPCODE_W, 4 — opcode width, ≥4. When OPCODE_W>4, any nonzero bit above bit 3 makes the opcode illegal.
- MEM_TIMEOUT, 0 — maximum cycles to wait in MEM for MemReady. 0 disables the timeout.
- CNT_W, 16 — width of the retired-instruction counter.

- Clock  in  1  sole clock, rising edge.
- Reset  in  1  synchronous, active-high.
- Opcode  in  OPCODE_W  instruction-register opcode field; sampled in DECODE.
- InstrReady  in  1  instruction memory has valid data this cycle.
- MemReady  in  1  data memory completes the access this cycle.
- Zero  in  1  ALU zero flag.
- PcWrite  out  1  load the PC (PC+1 in FETCH, branch target in EXEC).
- PcSrc  out  1  1 = branch target, 0 = PC+1.
- IrWrite  out  1  load the instruction register.
- RegDst, AluSrc, MemToReg, Shift, Branch, MemRead, MemWrite, RegWrite  out  1 each  datapath controls.
- AluOp  out  2  ALU operation class.
- State  out  3  current state, for debug.
- Illegal  out  1  one-cycle pulse on an illegal opcode.
- MemErr  out  1  one-cycle pulse on a MEM timeout.
- Halted  out  1  core halted; only present/active with MULTICYCLE_CU_TRAP_EN.
- Retired  out  CNT_W  count of completed instructions.

## Operation
- States and encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Encodings 6 and 7 → FETCH on the next edge.
- **FETCH**
  - IrWrite = PcWrite = InstrReady, PcSrc=0.
  - Stay in FETCH while InstrReady=0; → DECODE when InstrReady=1.
- **DECODE**
  - Latch Opcode into an internal register.
  - Legal opcode → EXEC.
  - Illegal opcode → Illegal=1 for this cycle, then → FETCH (or → HALT with the macro).
  - Legal set: 0000, 0001, 0010, 1001, 1010, 1011, 1100, 1101, 1111.
- **Decoded controls** (from the latched opcode, held constant through EXEC, MEM and WB):

  | Class | Opcodes | RegDst | AluSrc | AluOp | MemToReg | Shift |
  |---|---|---|---|---|---|---|
  | R-type | 0000, 0001 | 1 | 0 | 10 | 0 | 0 |
  | Shift | 0010 | 1 | 0 | 10 | 0 | 1 |
  | I-type | 1001, 1010, 1011 | 0 | 1 | 11 | 0 | 0 |
  | LW | 1100 | 0 | 1 | 00 | 1 | 0 |
  | SW | 1101 | 0 | 1 | 00 | 0 | 0 |
  | BEQ | 1111 | 0 | 0 | 01 | 0 | 0 |

- **EXEC**
  - BEQ: Branch=1, PcSrc=1, PcWrite=Zero, then → FETCH. Retired increments on this edge.
  - LW/SW → MEM; all others → WB.
- **MEM**
  - LW holds MemRead=1; SW holds MemWrite=1; stay in MEM while MemReady=0.
  - On MemReady=1: LW → WB; SW → FETCH and Retired increments.
  - A wait counter clears on MEM entry. If MEM_TIMEOUT≠0 and the count reaches MEM_TIMEOUT with MemReady still 0: MemErr=1 for that cycle, → FETCH, no write-back, Retired unchanged.
  - MemReady=1 on the same cycle as the timeout wins: normal completion.
- **WB**
  - RegWrite=1 for exactly one cycle, then → FETCH. Retired increments.
- **Retired** wraps modulo 2^CNT_W.
- Any output not listed above for a state is 0.

## Timing
- **Reset**
  - Reset has priority over every transition.
  - While Reset=1, all outputs are forced to 0 combinationally.
  - At the first edge with Reset=1: State=FETCH, Retired=0, opcode register=0, wait counter=0, Halted=0.
  - Reset mid-instruction abandons the instruction: no RegWrite, no retirement.
- **Latency with no wait states** (cycles, FETCH to next FETCH): R/shift/I = 4, LW = 5, SW = 4, BEQ = 3. Each InstrReady-low cycle adds 1; each MemReady-low cycle adds 1.
- **Output timing**: all outputs are Moore (State plus latched opcode), except the InstrReady-, MemReady- and Zero-qualified strobes, which are combinational in the same cycle.
- **Opcode sampling**: Opcode is sampled only on the DECODE edge; changes in any other state are ignored.

## Configuration
- **MULTICYCLE_CU_TRAP_EN**
  - Defined: an illegal opcode sends DECODE → HALT. HALT drives Halted=1, all other controls 0, and stays until Reset. Illegal still pulses in DECODE.
  - Undefined: an illegal opcode is a NOP (DECODE → FETCH, Illegal pulses). The HALT state is unreachable and Halted is tied to 0.

## Test plan
- ADD (0001), InstrReady=1 throughout → state sequence 0,1,2,4,0; RegDst=1 and AluOp=10 in EXEC and WB; RegWrite high only in WB; Retired 0→1.
- LW (1100) with MemReady low for 3 cycles → MemRead high for 4 MEM cycles, MemToReg=1 from EXEC to WB, one RegWrite pulse; total 8 cycles.
- BEQ (1111): Zero=1 → PcWrite=1, PcSrc=1 in EXEC; Zero=0 → PcWrite=0 in EXEC; both return to FETCH after 3 cycles.
- MEM_TIMEOUT=2, SW, MemReady held 0 → MemErr pulses, → FETCH, Retired unchanged, no RegWrite.
- Opcode 0100 → Illegal pulses in DECODE. Without the macro, next state FETCH. With MULTICYCLE_CU_TRAP_EN, Halted=1 and held until Reset.
- Reset asserted in MEM during LW → next state FETCH, all outputs 0 while Reset=1, Retired=0; CNT_W=2 with 5 ADDs after reset → Retired=1 (wrap).

Source files
------------

// File: rtl/multicycle_cu.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_cu
// Desc     : Multi-cycle Moore control unit for the 16-bit CPU. Sequences each
//            instruction through FETCH, DECODE, EXEC, MEM and WB. Handles
//            memory wait states, an optional MEM timeout, illegal opcodes and
//            a retired-instruction counter.
// Options  : MULTICYCLE_CU_TRAP_EN - an illegal opcode halts the core
//            (HALT state, Halted=1) instead of being treated as a NOP.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_cu #(
    parameter int OPCODE_W    = 4,
    parameter int MEM_TIMEOUT = 0,
    parameter int CNT_W       = 16
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                InstrReady,
    input  logic                MemReady,
    input  logic                Zero,
    output logic                PcWrite,
    output logic                PcSrc,
    output logic                IrWrite,
    output logic                RegDst,
    output logic                AluSrc,
    output logic                MemToReg,
    output logic                Shift,
    output logic                Branch,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                RegWrite,
    output logic [1:0]          AluOp,
    output logic [2:0]          State,
    output logic                Illegal,
    output logic                MemErr,
    output logic                Halted,
    output logic [CNT_W-1:0]    Retired
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    // Wait counter only needs to reach MEM_TIMEOUT; it saturates there.
    localparam int                WAIT_W     = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    state_t             state;
    logic [3:0]         op_q;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]   retired_q;

    logic               upper_nz;
    logic               op_legal;
    logic               is_lw;
    logic               is_sw;
    logic               is_beq;
    logic               mem_timeout;

    logic               dec_reg_dst;
    logic               dec_alu_src;
    logic [1:0]         dec_alu_op;
    logic               dec_mem_to_reg;
    logic               dec_shift;

    // Opcode bits above the 4-bit field must be zero for a legal instruction.
    if (OPCODE_W > 4) begin : g_wide_opcode
        assign upper_nz = |Opcode[OPCODE_W-1:4];
    end else begin : g_narrow_opcode
        assign upper_nz = 1'b0;
    end

    // Legality of the opcode presented to DECODE.
    always_comb begin
        case (Opcode[3:0])
            4'b0000, 4'b0001, 4'b0010,
            4'b1001, 4'b1010, 4'b1011,
            4'b1100, 4'b1101, 4'b1111: op_legal = ~upper_nz;
            default:                   op_legal = 1'b0;
        endcase
    end

    assign is_lw  = (op_q == 4'b1100);
    assign is_sw  = (op_q == 4'b1101);
    assign is_beq = (op_q == 4'b1111);

    // A timeout fires only while MemReady is still low; a late MemReady wins.
    assign mem_timeout = (MEM_TIMEOUT != 0) && (state == MEM) && !MemReady &&
                         (wait_cnt == WAIT_LIMIT);

    // Class decode of the latched opcode into datapath controls.
    always_comb begin
        dec_reg_dst    = 1'b0;
        dec_alu_src    = 1'b0;
        dec_alu_op     = 2'b00;
        dec_mem_to_reg = 1'b0;
        dec_shift      = 1'b0;
        case (op_q)
            4'b0000, 4'b0001: begin
                dec_reg_dst = 1'b1;
                dec_alu_op  = 2'b10;
            end
            4'b0010: begin
                dec_reg_dst = 1'b1;
                dec_alu_op  = 2'b10;
                dec_shift   = 1'b1;
            end
            4'b1001, 4'b1010, 4'b1011: begin
                dec_alu_src = 1'b1;
                dec_alu_op  = 2'b11;
            end
            4'b1100: begin
                dec_alu_src    = 1'b1;
                dec_mem_to_reg = 1'b1;
            end
            4'b1101: begin
                dec_alu_src = 1'b1;
            end
            4'b1111: begin
                dec_alu_op = 2'b01;
            end
            default: ;
        endcase
    end

    // Instruction sequencer: state, latched opcode, MEM wait counter, retire count.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= FETCH;
            op_q      <= 4'b0000;
            wait_cnt  <= '0;
            retired_q <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (InstrReady) begin
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    op_q <= Opcode[3:0];
                    if (op_legal) begin
                        state <= EXEC;
                    end else begin
`ifdef MULTICYCLE_CU_TRAP_EN
                        state <= HALT;
`else
                        state <= FETCH;
`endif
                    end
                end
                EXEC: begin
                    wait_cnt <= '0;
                    if (is_beq) begin
                        state     <= FETCH;
                        retired_q <= retired_q + 1'b1;
                    end else if (is_lw || is_sw) begin
                        state <= MEM;
                    end else begin
                        state <= WB;
                    end
                end
                MEM: begin
                    if (MemReady) begin
                        if (is_lw) begin
                            state <= WB;
                        end else begin
                            state     <= FETCH;
                            retired_q <= retired_q + 1'b1;
                        end
                    end else if (mem_timeout) begin
                        state <= FETCH;
                    end else if (wait_cnt != WAIT_LIMIT) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                WB: begin
                    state     <= FETCH;
                    retired_q <= retired_q + 1'b1;
                end
`ifdef MULTICYCLE_CU_TRAP_EN
                HALT: begin
                    state <= HALT;
                end
`endif
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

    // Control strobes from state and latched opcode; forced low during reset.
    always_comb begin
        PcWrite  = 1'b0;
        PcSrc    = 1'b0;
        IrWrite  = 1'b0;
        RegDst   = 1'b0;
        AluSrc   = 1'b0;
        MemToReg = 1'b0;
        Shift    = 1'b0;
        Branch   = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        AluOp    = 2'b00;
        State    = 3'd0;
        Illegal  = 1'b0;
        MemErr   = 1'b0;
        Halted   = 1'b0;
        Retired  = '0;
        if (!Reset) begin
            State   = state;
            Retired = retired_q;
            case (state)
                FETCH: begin
                    IrWrite = InstrReady;
                    PcWrite = InstrReady;
                end
                DECODE: begin
                    Illegal = ~op_legal;
                end
                EXEC, MEM, WB: begin
                    RegDst   = dec_reg_dst;
                    AluSrc   = dec_alu_src;
                    AluOp    = dec_alu_op;
                    MemToReg = dec_mem_to_reg;
                    Shift    = dec_shift;
                    if ((state == EXEC) && is_beq) begin
                        Branch  = 1'b1;
                        PcSrc   = 1'b1;
                        PcWrite = Zero;
                    end
                    if (state == MEM) begin
                        MemRead  = is_lw;
                        MemWrite = is_sw;
                        MemErr   = mem_timeout;
                    end
                    if (state == WB) begin
                        RegWrite = 1'b1;
                    end
                end
`ifdef MULTICYCLE_CU_TRAP_EN
                HALT: begin
                    Halted = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_cu.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_cu
// Desc     : Self-checking bench for multicycle_cu. Two instances share one
//            stimulus: A (OPCODE_W=5, no timeout, CNT_W=2) and
//            B (OPCODE_W=4, MEM_TIMEOUT=2, CNT_W=16). Every cycle both are
//            compared with an instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_cu;

`ifdef MULTICYCLE_CU_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    // Phase numbers are the architectural State encodings.
    localparam int P_FETCH = 0, P_DECODE = 1, P_EXEC = 2, P_MEM = 3, P_WB = 4, P_HALT = 5;
    // Instruction classes.
    localparam int K_ILL = -1, K_R = 0, K_SH = 1, K_I = 2, K_LW = 3, K_SW = 4, K_BEQ = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       ir  = 1'b0;
    logic       mr  = 1'b0;
    logic       zf  = 1'b0;
    logic [4:0] op  = 5'd0;

    logic [1:0] pcw, pcs, irw, rdst, asrc, m2r, shf, brn, mrd, mwr, rgw, ill, merr, hlt;
    logic [1:0] aop [2];
    logic [2:0] stt [2];
    logic [1:0]  ret_a;
    logic [15:0] ret_b;

    multicycle_cu #(.OPCODE_W(5), .MEM_TIMEOUT(0), .CNT_W(2)) dut_a (
        .Clock(clk), .Reset(rst), .Opcode(op), .InstrReady(ir), .MemReady(mr), .Zero(zf),
        .PcWrite(pcw[0]), .PcSrc(pcs[0]), .IrWrite(irw[0]), .RegDst(rdst[0]), .AluSrc(asrc[0]),
        .MemToReg(m2r[0]), .Shift(shf[0]), .Branch(brn[0]), .MemRead(mrd[0]), .MemWrite(mwr[0]),
        .RegWrite(rgw[0]), .AluOp(aop[0]), .State(stt[0]), .Illegal(ill[0]), .MemErr(merr[0]),
        .Halted(hlt[0]), .Retired(ret_a)
    );

    multicycle_cu #(.OPCODE_W(4), .MEM_TIMEOUT(2), .CNT_W(16)) dut_b (
        .Clock(clk), .Reset(rst), .Opcode(op[3:0]), .InstrReady(ir), .MemReady(mr), .Zero(zf),
        .PcWrite(pcw[1]), .PcSrc(pcs[1]), .IrWrite(irw[1]), .RegDst(rdst[1]), .AluSrc(asrc[1]),
        .MemToReg(m2r[1]), .Shift(shf[1]), .Branch(brn[1]), .MemRead(mrd[1]), .MemWrite(mwr[1]),
        .RegWrite(rgw[1]), .AluOp(aop[1]), .State(stt[1]), .Illegal(ill[1]), .MemErr(merr[1]),
        .Halted(hlt[1]), .Retired(ret_b)
    );

    // Per-instance configuration as seen by the model.
    int cfg_tmo [2] = '{0, 2};
    int cfg_cw  [2] = '{2, 16};

    // Reference model state per instance.
    int m_ph   [2] = '{0, 0};
    int m_kind [2] = '{0, 0};
    int m_wait [2] = '{0, 0};
    int m_ret  [2] = '{0, 0};

    // Controls per class: {RegDst, AluSrc, AluOp[1:0], MemToReg, Shift}.
    logic [5:0] ctl_tab [6] = '{6'b1_0_10_0_0, 6'b1_0_10_0_1, 6'b0_1_11_0_0,
                                6'b0_1_00_1_0, 6'b0_1_00_0_0, 6'b0_0_01_0_0};
    int legal_ops [9] = '{0, 1, 2, 9, 10, 11, 12, 13, 15};

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [4:0] op;
        bit         zero;
        int         il;     // InstrReady-low cycles before fetch
        int         ml;     // MemReady-low cycles on MEM entry
        int         cyc_a;
        int         cyc_b;
        int         inc_a;
        int         inc_b;
    } vec_t;
    vec_t vt [14];

    function automatic int kind_of(input int opv);
        case (opv)
            0, 1:        return K_R;
            2:           return K_SH;
            9, 10, 11:   return K_I;
            12:          return K_LW;
            13:          return K_SW;
            15:          return K_BEQ;
            default:     return K_ILL;
        endcase
    endfunction

    function automatic int op_seen(input int k);
        return (k == 0) ? int'(op) : int'(op[3:0]);
    endfunction

    function automatic int ret_mask(input int k);
        return (1 << cfg_cw[k]) - 1;
    endfunction

    function automatic logic [18:0] act_pack(input int k);
        return {pcw[k], pcs[k], irw[k], rdst[k], asrc[k], m2r[k], shf[k], brn[k],
                mrd[k], mwr[k], rgw[k], aop[k], stt[k], ill[k], merr[k], hlt[k]};
    endfunction

    // Expected outputs for the current cycle from model state and live inputs.
    function automatic logic [18:0] exp_pack(input int k);
        logic [18:0] e;
        logic [5:0]  c;
        e = '0;
        if (rst) return e;
        e[5:3] = 3'(m_ph[k]);
        if (m_ph[k] == P_FETCH) begin
            e[18] = ir;
            e[16] = ir;
        end else if (m_ph[k] == P_DECODE) begin
            e[2] = (kind_of(op_seen(k)) == K_ILL);
        end else if (m_ph[k] >= P_EXEC && m_ph[k] <= P_WB) begin
            c = ctl_tab[m_kind[k]];
            e[15]  = c[5];
            e[14]  = c[4];
            e[7:6] = c[3:2];
            e[13]  = c[1];
            e[12]  = c[0];
            if (m_ph[k] == P_EXEC && m_kind[k] == K_BEQ) begin
                e[11] = 1'b1;
                e[17] = 1'b1;
                e[18] = zf;
            end
            if (m_ph[k] == P_MEM) begin
                e[10] = (m_kind[k] == K_LW);
                e[9]  = (m_kind[k] == K_SW);
                e[1]  = !mr && cfg_tmo[k] != 0 && m_wait[k] == cfg_tmo[k];
            end
            if (m_ph[k] == P_WB) e[8] = 1'b1;
        end else if (m_ph[k] == P_HALT) begin
            e[0] = 1'b1;
        end
        return e;
    endfunction

    // Instruction-level progress of the model on a clock edge.
    task automatic advance(input int k);
        if (rst) begin
            m_ph[k] = P_FETCH; m_kind[k] = K_R; m_wait[k] = 0; m_ret[k] = 0;
            return;
        end
        case (m_ph[k])
            P_FETCH:  if (ir) m_ph[k] = P_DECODE;
            P_DECODE: begin
                m_kind[k] = kind_of(op_seen(k));
                if (m_kind[k] != K_ILL) m_ph[k] = P_EXEC;
                else m_ph[k] = TRAP ? P_HALT : P_FETCH;
            end
            P_EXEC: begin
                if (m_kind[k] == K_BEQ) begin m_ret[k]++; m_ph[k] = P_FETCH; end
                else if (m_kind[k] == K_LW || m_kind[k] == K_SW) begin m_wait[k] = 0; m_ph[k] = P_MEM; end
                else m_ph[k] = P_WB;
            end
            P_MEM: begin
                if (mr) begin
                    if (m_kind[k] == K_LW) m_ph[k] = P_WB;
                    else begin m_ret[k]++; m_ph[k] = P_FETCH; end
                end else if (cfg_tmo[k] != 0 && m_wait[k] == cfg_tmo[k]) begin
                    m_ph[k] = P_FETCH;
                end else begin
                    m_wait[k]++;
                end
            end
            P_WB: begin m_ret[k]++; m_ph[k] = P_FETCH; end
            default: ;
        endcase
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] act_ret(input int k);
        return (k == 0) ? 32'(ret_a) : 32'(ret_b);
    endfunction

    // Apply inputs mid-cycle and compare both instances against the model.
    task automatic drive(input logic r, input logic i, input logic m, input logic z, input logic [4:0] o);
        @(negedge clk);
        rst = r; ir = i; mr = m; zf = z; op = o;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("outputs[%0d]", k), 32'(act_pack(k)), 32'(exp_pack(k)));
            chk($sformatf("retired[%0d]", k), act_ret(k), rst ? 32'd0 : 32'(m_ret[k] & ret_mask(k)));
        end
    endtask

    task automatic clk_edge();
        @(posedge clk);
        for (int k = 0; k < 2; k++) advance(k);
        #1;
    endtask

    task automatic step(input logic r, input logic i, input logic m, input logic z, input logic [4:0] o);
        drive(r, i, m, z, o);
        clk_edge();
    endtask

    // One instruction from FETCH back to FETCH, with latency and retire checks.
    task automatic run_vec(input vec_t v, input string tag);
        int c;
        bit done [2];
        int cyc [2];
        int start [2];
        c = 0;
        for (int k = 0; k < 2; k++) begin done[k] = 1'b0; cyc[k] = 0; start[k] = m_ret[k]; end
        while (!(done[0] && done[1]) && c < 40) begin
            drive(1'b0, (c == v.il), !(c >= v.il + 3 && c < v.il + 3 + v.ml), v.zero, v.op);
            clk_edge();
            for (int k = 0; k < 2; k++) begin
                if (!done[k] && c >= v.il && stt[k] == 3'd0) begin
                    done[k] = 1'b1;
                    cyc[k]  = c + 1;
                end
            end
            c++;
        end
        chk({tag, " latency_a"}, 32'(cyc[0]), 32'(v.cyc_a));
        chk({tag, " latency_b"}, 32'(cyc[1]), 32'(v.cyc_b));
        chk({tag, " retired_a"}, act_ret(0), 32'((start[0] + v.inc_a) & ret_mask(0)));
        chk({tag, " retired_b"}, act_ret(1), 32'((start[1] + v.inc_b) & ret_mask(1)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] rop;
        vt[0]  = '{5'b00001, 1'b0, 0, 0, 4, 4, 1, 1};  // ADD
        vt[1]  = '{5'b00000, 1'b0, 2, 0, 6, 6, 1, 1};  // R-type, 2 fetch waits
        vt[2]  = '{5'b00010, 1'b0, 0, 0, 4, 4, 1, 1};  // shift
        vt[3]  = '{5'b01001, 1'b0, 1, 0, 5, 5, 1, 1};  // I-type, 1 fetch wait
        vt[4]  = '{5'b01010, 1'b0, 0, 0, 4, 4, 1, 1};
        vt[5]  = '{5'b01011, 1'b0, 0, 0, 4, 4, 1, 1};
        vt[6]  = '{5'b01100, 1'b0, 0, 0, 5, 5, 1, 1};  // LW
        vt[7]  = '{5'b01100, 1'b0, 0, 3, 8, 6, 1, 0};  // LW, 3 waits: B times out
        vt[8]  = '{5'b01100, 1'b0, 0, 2, 7, 7, 1, 1};  // LW, ready on B's timeout cycle
        vt[9]  = '{5'b01101, 1'b0, 0, 0, 4, 4, 1, 1};  // SW
        vt[10] = '{5'b01101, 1'b0, 0, 5, 9, 6, 1, 0};  // SW, B times out
        vt[11] = '{5'b01101, 1'b0, 0, 2, 6, 6, 1, 1};  // SW, ready wins over timeout
        vt[12] = '{5'b01111, 1'b1, 0, 0, 3, 3, 1, 1};  // BEQ taken
        vt[13] = '{5'b01111, 1'b0, 0, 0, 3, 3, 1, 1};  // BEQ not taken

        // Reset and post-reset state.
        step(1'b1, 1'b1, 1'b1, 1'b1, 5'b01100);
        step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reset_outputs[%0d]", k), 32'(act_pack(k)), 32'd0);
            chk($sformatf("reset_retired[%0d]", k), act_ret(k), 32'd0);
        end
        clk_edge();

        // Table-driven instruction sweep.
        for (int i = 0; i < 14; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // Retired wraps on the 2-bit counter: 5 ADDs after reset leave A at 1.
        step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        for (int i = 0; i < 5; i++) run_vec(vt[0], $sformatf("wrap%0d", i));
        chk("wrap_retired_a", act_ret(0), 32'd1);
        chk("wrap_retired_b", act_ret(1), 32'd5);

        // Reset in MEM during LW abandons the instruction.
        step(1'b0, 1'b1, 1'b0, 1'b0, 5'b01100);
        step(1'b0, 1'b0, 1'b0, 1'b0, 5'b01100);
        step(1'b0, 1'b0, 1'b0, 1'b0, 5'b01100);
        step(1'b0, 1'b0, 1'b0, 1'b0, 5'b01100);
        chk("lw_in_mem_a", 32'(stt[0]), 32'd3);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 5'b01100);
        chk("rst_forced_a", 32'(act_pack(0)), 32'd0);
        chk("rst_forced_b", 32'(act_pack(1)), 32'd0);
        clk_edge();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 5'b01100);
        chk("after_rst_state_a", 32'(stt[0]), 32'd0);
        chk("after_rst_regwrite_a", 32'(rgw[0]), 32'd0);
        chk("after_rst_retired_a", act_ret(0), 32'd0);
        clk_edge();

        // Illegal opcode 0100 on both instances.
        step(1'b0, 1'b1, 1'b1, 1'b0, 5'b00100);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 5'b00100);
        chk("illegal_pulse_a", 32'(ill[0]), 32'd1);
        chk("illegal_pulse_b", 32'(ill[1]), 32'd1);
        clk_edge();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 5'b00100);
        chk("after_illegal_state_a", 32'(stt[0]), TRAP ? 32'd5 : 32'd0);
        chk("after_illegal_halted_b", 32'(hlt[1]), TRAP ? 32'd1 : 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);

        // Upper opcode bit set: illegal on the 5-bit instance, ADD on the 4-bit one.
        step(1'b0, 1'b1, 1'b1, 1'b0, 5'b10001);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 5'b10001);
        chk("upper_illegal_a", 32'(ill[0]), 32'd1);
        chk("upper_legal_b", 32'(ill[1]), 32'd0);
        clk_edge();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 5'b10001);
        chk("upper_retired_b", act_ret(1), 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(1) == 1) rop = 5'(legal_ops[$urandom_range(8)]);
            else rop = 5'($urandom_range(31));
            step($urandom_range(99) == 0, $urandom_range(9) < 7, $urandom_range(1) == 1,
                 $urandom_range(1) == 1, rop);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
